// File: rtl/decode_output_queue.sv
// First-word-fall-through queue between the per-format decoders and dispatch.
// One slot is held back so that a registered decoder's last result still fits after stall_o rises.
module decode_output_queue #(
    parameter int depth                   = 4,
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int bodySize                = 28
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic [instMinIdWidth-1:0]          instMinId_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic [bodySize-1:0]                instructionBody_i,
    output logic                               stall_o,
    output logic                               enable_o,
    input  logic                               dispatchReady_i,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [bodySize-1:0]                instructionBody_o,
    output logic [$clog2(depth):0]             count_o,
    output logic                               overflow_o
);

    localparam int PTR_W   = $clog2(depth);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = opcodeSize + addressWidth + funcUnitCodeSize + instructionCounterWidth
                           + instMinIdWidth + 1 + PidSize + TidSize + bodySize;

    logic [ENTRY_W-1:0] mem_q [depth];
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               empty, full, pop, push;
    logic [ENTRY_W-1:0] wrEntry, head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(depth));
    assign pop   = !empty && dispatchReady_i;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push  = enable_i && (!full || pop);

    assign wrEntry = {opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
                      instMinId_i, is64Bit_i, instPid_i, instTid_i, instructionBody_i};

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (enable_i && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; the occupancy counter alone defines what is valid.
    always_ff @(posedge clock_i) begin
        if (push && !flush_i) mem_q[wrPtr_q] <= wrEntry;
    end

    assign head = empty ? '0 : mem_q[rdPtr_q];

    assign {opcode_o, instructionAddress_o, functionalUnitType_o, instMajId_o,
            instMinId_o, is64Bit_o, instPid_o, instTid_o, instructionBody_o} = head;

    assign enable_o   = !empty;
    assign stall_o    = (count_q >= CNT_W'(depth - 1));
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_decode_output_queue.sv
// Randomised and directed stimulus for decode_output_queue, checked by a queue-based model
// and a scoreboard monitor that compares every entry dispatch accepts.
module tb_decode_output_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [11:0] opc;
        logic [63:0] addr;
        logic [2:0]  fu;
        logic [63:0] maj;
        logic [6:0]  mnr;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [27:0] body;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        dispatchReady_i = 1'b0;
    logic [11:0] opcode_i = '0;
    logic [63:0] addr_i = '0;
    logic [2:0]  fu_i = '0;
    logic [63:0] maj_i = '0;
    logic [6:0]  mnr_i = '0;
    logic        is64_i = 1'b0;
    logic [19:0] pid_i = '0;
    logic [15:0] tid_i = '0;
    logic [27:0] body_i = '0;

    logic        stall_o, enable_o, overflow_o, is64_o;
    logic [11:0] opcode_o;
    logic [63:0] addr_o, maj_o;
    logic [2:0]  fu_o;
    logic [6:0]  mnr_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [27:0] body_o;
    logic [2:0]  count_o;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t model[$];
    ent_t exp_q[$];
    bit   ovf_m = 1'b0;

    decode_output_queue dut (
        .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .opcode_i(opcode_i), .instructionAddress_i(addr_i), .functionalUnitType_i(fu_i),
        .instMajId_i(maj_i), .instMinId_i(mnr_i), .is64Bit_i(is64_i), .instPid_i(pid_i),
        .instTid_i(tid_i), .instructionBody_i(body_i),
        .stall_o(stall_o), .enable_o(enable_o), .dispatchReady_i(dispatchReady_i),
        .opcode_o(opcode_o), .instructionAddress_o(addr_o), .functionalUnitType_o(fu_o),
        .instMajId_o(maj_o), .instMinId_o(mnr_o), .is64Bit_o(is64_o), .instPid_o(pid_o),
        .instTid_o(tid_o), .instructionBody_o(body_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_i && enable_o && dispatchReady_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_opcode", {52'd0, opcode_o}, {52'd0, e.opc});
                chk("pop_addr", addr_o, e.addr);
                chk("pop_maj", maj_o, e.maj);
                chk("pop_misc", {fu_o, mnr_o, is64_o, pid_o, tid_o, body_o},
                                {e.fu, e.mnr, e.is64, e.pid, e.tid, e.body});
            end
        end
    end

    task automatic step(input bit en, input bit rdy, input bit fl,
                        input logic [63:0] maj, input logic [11:0] opc, input logic [63:0] addr);
        ent_t e;
        bit   p, full;
        @(posedge clk);
        #1;
        chk("count", {61'd0, count_o}, 64'(model.size()));
        chk("stall", {63'd0, stall_o}, {63'd0, model.size() >= DEPTH - 1});
        chk("overflow", {63'd0, overflow_o}, {63'd0, ovf_m});
        chk("enable", {63'd0, enable_o}, {63'd0, model.size() != 0});
        if (model.size() != 0) begin
            chk("head_maj", maj_o, model[0].maj);
            chk("head_opcode", {52'd0, opcode_o}, {52'd0, model[0].opc});
        end
        e.opc = opc; e.addr = addr; e.maj = maj;
        e.fu = 3'($urandom); e.mnr = 7'($urandom); e.is64 = 1'($urandom);
        e.pid = 20'($urandom); e.tid = 16'($urandom); e.body = 28'($urandom);
        enable_i = en; dispatchReady_i = rdy; flush_i = fl;
        opcode_i = e.opc; addr_i = e.addr; maj_i = e.maj; fu_i = e.fu; mnr_i = e.mnr;
        is64_i = e.is64; pid_i = e.pid; tid_i = e.tid; body_i = e.body;
        if (fl) begin
            model.delete();
        end else begin
            full = (model.size() == DEPTH);
            p = rdy && (model.size() != 0);
            if (p) exp_q.push_back(model.pop_front());
            if (en && (!full || p)) model.push_back(e);
            if (en && full && !p) ovf_m = 1'b1;
        end
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, rdy, 1'b0, {$urandom, $urandom}, 12'($urandom), {$urandom, $urandom});
    endtask

    task automatic push_step(input bit rdy, input logic [63:0] maj);
        step(1'b1, rdy, 1'b0, maj, 12'($urandom), {$urandom, $urandom});
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_enable"}, {63'd0, enable_o}, 64'd0);
        chk({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
        chk({tag, "_count"}, {61'd0, count_o}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow_o}, 64'd0);
        chk({tag, "_head"}, {52'd0, opcode_o} | addr_o | maj_o, 64'd0);
        chk({tag, "_head_misc"}, {fu_o, mnr_o, is64_o, pid_o, tid_o, body_o}, 75'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_cleared("reset");
        @(posedge clk); #1;
        reset_i = 1'b1;

        // Reset and first push
        step(1'b1, 1'b0, 1'b0, 64'd0, 12'h010, 64'h40);
        idle_step(1'b1);

        // Fill, stall timing, in-flight fourth push, overflow, drain
        for (int i = 1; i <= 5; i++) push_step(1'b0, 64'(i));
        for (int i = 0; i < 4; i++) idle_step(1'b1);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) push_step(1'b0, 64'(i));
        push_step(1'b1, 64'd6);
        for (int i = 0; i < 4; i++) idle_step(1'b1);

        // Wrap-around streaming
        for (int i = 0; i < 64; i++) push_step(1'b1, 64'(i));
        idle_step(1'b1);
        idle_step(1'b0);

        // Flush with simultaneous push
        for (int i = 0; i < 3; i++) push_step(1'b0, 64'(100 + i));
        step(1'b1, 1'b0, 1'b1, 64'd200, 12'h0ff, 64'h80);
        idle_step(1'b0);

        // Refill, then asynchronous reset between edges
        push_step(1'b0, 64'd300);
        push_step(1'b0, 64'd301);
        idle_step(1'b0);
        #3;
        reset_i = 1'b0;
        #1;
        check_cleared("async_reset");
        model.delete();
        ovf_m = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0), {$urandom, $urandom},
                 12'($urandom), {$urandom, $urandom});
        end
        idle_step(1'b0);
        #6;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
